// File: rtl/if_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_queue_pkg
// Shared definitions for the fetch -> decode instruction queue. The fetch
// and decode stages use the same entry layout {ex, pc, inst}, with inst in
// the least significant bits.
// -----------------------------------------------------------------------------
package if_id_queue_pkg;

    // Number of exception sources carried with each fetched instruction.
    localparam int NUM_EX  = 5;
    localparam int EXBITS  = NUM_EX;
    localparam int INST_DW = 32;

    // Queue entry as seen by the fetch and decode stages (default widths).
    typedef struct packed {
        logic [EXBITS-1:0]  ex;
        logic [INST_DW-1:0] pc;
        logic [INST_DW-1:0] inst;
    } iq_entry_t;

    // Bit offset of the PC field inside a packed {ex, pc, inst} word.
    function automatic int unsigned iq_pc_lsb(input int unsigned dw);
        return dw;
    endfunction

    // Bit offset of the exception field inside a packed {ex, pc, inst} word.
    function automatic int unsigned iq_ex_lsb(input int unsigned dw);
        return 2 * dw;
    endfunction

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// DEPTH-entry first-word-fall-through queue between fetch and decode.
// Each entry holds {ex, pc, inst}. The branch-delay-slot flag is produced
// at dequeue time: when decode accepts a branch, the next instruction to
// be dequeued is tagged, even if it arrives later.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   flush                    synchronous clear of entries and delay-slot state
//   in_valid/in_ready        fetch handshake; in_ready = (count < DEPTH)
//   in_ex/in_pc/in_inst      fetch payload
//   out_valid/out_ready      decode handshake; out_valid = (count != 0)
//   id_branch                head being popped is a branch/jump
//   out_bd                   head sits in a branch delay slot
//   out_ex/out_pc/out_inst   head payload, zero when the queue is empty
//   count                    current occupancy
// -----------------------------------------------------------------------------
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int EX_W  = EXBITS,
    parameter int DW    = INST_DW
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EX_W-1:0]          in_ex,
    input  logic [DW-1:0]            in_pc,
    input  logic [DW-1:0]            in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     id_branch,
    output logic                     out_bd,
    output logic [EX_W-1:0]          out_ex,
    output logic [DW-1:0]           out_pc,
    output logic [DW-1:0]            out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int EW     = EX_W + 2 * DW;
    localparam int PC_LSB = int'(iq_pc_lsb(DW));
    localparam int EX_LSB = int'(iq_ex_lsb(DW));

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          bd_pend_q, bd_pend_d;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    // in_ready looks only at occupancy, so a full queue refuses a push even
    // when decode pops in the same cycle (no out_ready -> in_ready path).
    assign in_ready_s  = (count_q < DEPTH_C);
    assign out_valid_s = (count_q != {CW{1'b0}});
    assign push_s      = in_valid & in_ready_s & ~flush;
    assign pop_s       = out_valid_s & out_ready & ~flush;
    assign head_s      = mem_q[rd_ptr_q];

    // Entry storage: written on push only; contents need no reset because
    // the outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_ex, in_pc, in_inst};
        end
    end

    // Next-state for pointers, occupancy and the pending delay-slot tag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        bd_pend_d = bd_pend_q;
        if (flush) begin
            wr_ptr_d  = {PW{1'b0}};
            rd_ptr_d  = {PW{1'b0}};
            count_d   = {CW{1'b0}};
            bd_pend_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                bd_pend_d = id_branch;
            end else begin
                rd_ptr_d  = rd_ptr_q;
                bd_pend_d = bd_pend_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset discards all contents immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            bd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            bd_pend_q <= bd_pend_d;
        end
    end

    // Head payload falls through from storage; forced to zero when empty.
    always_comb begin
        out_ex   = {EX_W{1'b0}};
        out_pc   = {DW{1'b0}};
        out_inst = {DW{1'b0}};
        if (out_valid_s) begin
            out_ex   = head_s[EX_LSB +: EX_W];
            out_pc   = head_s[PC_LSB +: DW];
            out_inst = head_s[0 +: DW];
        end else begin
            out_ex   = {EX_W{1'b0}};
            out_pc   = {DW{1'b0}};
            out_inst = {DW{1'b0}};
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_bd    = bd_pend_q & out_valid_s;
    assign count     = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ex;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic        id_branch;
    logic        out_bd;
    logic [4:0]  out_ex;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: a plain queue of {ex, pc, inst} plus the pending tag.
    logic [68:0] mq [$];
    logic        bd_m;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .EX_W(5), .DW(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ex     (in_ex),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .id_branch (id_branch),
        .out_bd    (out_bd),
        .out_ex    (out_ex),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        if (pc == 32'hBFC0_0000) return 32'h2402_0001;
        else return {pc[15:0], ~pc[15:0]};
    endfunction

    function automatic logic [4:0] ex_of(input logic [31:0] pc);
        return pc[6:2] ^ 5'h15;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and advance the model.
    task automatic apply(input logic f, input logic iv, input logic [31:0] pc,
                         input logic ordy, input logic idb);
        logic do_push;
        logic do_pop;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        in_ex     = ex_of(pc);
        out_ready = ordy;
        id_branch = idb;
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (f) begin
            mq.delete();
            bd_m = 1'b0;
        end else begin
            if (do_pop) begin
                bd_m = idb;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back({ex_of(pc), pc, inst_of(pc)});
        end
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [68:0] h;
        ev = (mq.size() != 0);
        h  = ev ? mq[0] : 69'd0;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
        chk({tag, ".out_bd"},    64'(out_bd),    64'(bd_m && ev));
        chk({tag, ".out_ex"},    64'(out_ex),    64'(h[68:64]));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(h[63:32]));
        chk({tag, ".out_inst"},  64'(out_inst),  64'(h[31:0]));
        chk({tag, ".count_le_depth"}, 64'(count <= 3'(DEPTH)), 64'(1'b1));
    endtask

    typedef struct {
        logic        f;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        idb;
        logic        ev;
        logic [2:0]  ecnt;
        logic        ebd;
        logic [31:0] epc;
        logic        erdy;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic f, input logic iv, input logic [31:0] pc,
                       input logic ordy, input logic idb, input logic ev,
                       input logic [2:0] ecnt, input logic ebd,
                       input logic [31:0] epc, input logic erdy);
        vec_t v;
        v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy; v.idb = idb;
        v.ev = ev; v.ecnt = ecnt; v.ebd = ebd; v.epc = epc; v.erdy = erdy;
        tbl.push_back(v);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0;
        in_inst = 32'd0; in_ex = 5'd0; out_ready = 1'b0; id_branch = 1'b0;
        bd_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.count",     64'(count),     64'd0);
        chk("reset.out_bd",    64'(out_bd),    64'd0);
        chk("reset.out_pc",    64'(out_pc),    64'd0);
        resetn = 1'b1;

        //    f     iv    pc            ordy  idb   ev    cnt   bd    head pc       rdy
        add(1'b0, 1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'hBFC00000, 1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h100,      1'b1);
        add(1'b0, 1'b1, 32'h104,      1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 32'h100,      1'b1);
        add(1'b0, 1'b1, 32'h108,      1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 32'h100,      1'b1);
        add(1'b0, 1'b1, 32'h10C,      1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'h100,      1'b0);
        add(1'b0, 1'b1, 32'h110,      1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'h100,      1'b0);
        add(1'b0, 1'b1, 32'h110,      1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 32'h104,      1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 32'h108,      1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 32'h10C,      1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h200,      1'b1);
        add(1'b0, 1'b1, 32'h204,      1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'h200,      1'b1);
        add(1'b0, 1'b1, 32'h208,      1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 32'h200,      1'b1);
        add(1'b1, 1'b1, 32'h20C,      1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b1, 32'h300,      1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h300,      1'b1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].idb);
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.count", i),     64'(count),     64'(tbl[i].ecnt));
            chk($sformatf("vec%0d.out_bd", i),    64'(out_bd),    64'(tbl[i].ebd));
            chk($sformatf("vec%0d.out_pc", i),    64'(out_pc),    64'(tbl[i].epc));
            chk($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(tbl[i].erdy));
            chk($sformatf("vec%0d.out_inst", i),  64'(out_inst),
                tbl[i].ev ? 64'(inst_of(tbl[i].epc)) : 64'd0);
            chk($sformatf("vec%0d.out_ex", i),    64'(out_ex),
                tbl[i].ev ? 64'(ex_of(tbl[i].epc)) : 64'd0);
        end

        // Steady streaming: two entries buffered, then push+pop every cycle.
        apply(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 32'h404, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'($urandom_range(1)));
            chk("stream.count", 64'(count), 64'd2);
            chk("stream.head_pc", 64'(out_pc), 64'(32'h404 + 32'(4 * i)));
            check_model("stream");
        end

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(19) == 0), 1'($urandom_range(1)),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(2) != 0),
                  1'($urandom_range(1)));
            check_model("rand");
        end

        // Asynchronous reset in the middle of traffic, away from any edge.
        apply(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 32'h504, 1'b0, 1'b0);
        check_model("prereset");
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset.out_valid", 64'(out_valid), 64'd0);
        chk("async_reset.count",     64'(count),     64'd0);
        chk("async_reset.in_ready",  64'(in_ready),  64'd1);
        chk("async_reset.out_pc",    64'(out_pc),    64'd0);
        mq.delete();
        bd_m = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_model("postreset");
        apply(1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
        check_model("postreset_push");

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule : tb_if_id_queue
